// File: rtl/mips_alu_ctrl_unit_if.sv
// Bundles the fetch, decode, execute and syscall signals of the MIPS helper unit.
// The DUT uses the slave side; the pipeline or bench drives the master side.
interface mips_alu_ctrl_unit_if;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] syscall_info;
  logic [31:0] std_out;
  logic        reg_dst;
  logic        jump;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic [2:0]  alu_control;
  logic        reg_write;
  logic        alu_src;
  logic        mem_write;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_out;
  logic        zero;
  logic        sys_out_valid;
  logic [31:0] sys_out_data;
  logic        halted;

  modport master (
    output pc, instr, syscall_info, std_out, src_a, src_b, alu_ctl,
    input  pc_plus4, reg_dst, jump, branch, mem_read, mem_to_reg, alu_control,
           reg_write, alu_src, mem_write, alu_out, zero,
           sys_out_valid, sys_out_data, halted
  );

  modport slave (
    input  pc, instr, syscall_info, std_out, src_a, src_b, alu_ctl,
    output pc_plus4, reg_dst, jump, branch, mem_read, mem_to_reg, alu_control,
           reg_write, alu_src, mem_write, alu_out, zero,
           sys_out_valid, sys_out_data, halted
  );
endinterface

// File: rtl/mips_alu_ctrl_unit.sv
// PC+4 incrementer, main/ALU control decoder and 32-bit ALU for the 5-stage MIPS pipeline.
// Only the syscall print/halt logic is clocked.
module mips_alu_ctrl_unit #(
  parameter logic [31:0] SYS_PRINT_INT = 32'd1,
  parameter logic [31:0] SYS_EXIT      = 32'd10
) (
  input logic            clk,
  input logic            reset,
  mips_alu_ctrl_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_sys;
  logic [31:0] alu_res;
  logic        unused_instr_bits;

  assign op                = bus.instr[31:26];
  assign funct             = bus.instr[5:0];
  assign is_sys            = (op == OP_RTYPE) && (funct == FN_SYSCALL);
  assign unused_instr_bits = ^bus.instr[25:6];

  assign bus.pc_plus4 = bus.pc + 32'd4;

  always_comb begin
    bus.reg_dst     = 1'b0;
    bus.jump        = 1'b0;
    bus.branch      = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_control = 3'b000;
    bus.reg_write   = 1'b0;
    bus.alu_src     = 1'b0;
    bus.mem_write   = 1'b0;
    case (op)
      OP_RTYPE: begin
        // Unsupported functs, syscall included, leave the instruction a NOP.
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
          end
          default: ;
        endcase
        case (funct)
          FN_ADD:  bus.alu_control = 3'b010;
          FN_SUB:  bus.alu_control = 3'b110;
          FN_AND:  bus.alu_control = 3'b000;
          FN_OR:   bus.alu_control = 3'b001;
          FN_SLT:  bus.alu_control = 3'b111;
          default: bus.alu_control = 3'b000;
        endcase
      end
      OP_LW: begin
        bus.reg_write   = 1'b1;
        bus.alu_src     = 1'b1;
        bus.mem_to_reg  = 1'b1;
        bus.mem_read    = 1'b1;
        bus.alu_control = 3'b010;
      end
      OP_SW: begin
        bus.alu_src     = 1'b1;
        bus.mem_write   = 1'b1;
        bus.alu_control = 3'b010;
      end
      OP_BEQ: begin
        bus.branch      = 1'b1;
        bus.alu_control = 3'b110;
      end
      OP_ADDI: begin
        bus.reg_write   = 1'b1;
        bus.alu_src     = 1'b1;
        bus.alu_control = 3'b010;
      end
      OP_J:    bus.jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (bus.alu_ctl)
      3'b000:  alu_res = bus.src_a & bus.src_b;
      3'b001:  alu_res = bus.src_a | bus.src_b;
      3'b010:  alu_res = bus.src_a + bus.src_b;
      3'b110:  alu_res = bus.src_a - bus.src_b;
      3'b111:  alu_res = {31'd0, $signed(bus.src_a) < $signed(bus.src_b)};
      3'b100:  alu_res = bus.src_a & ~bus.src_b;
      3'b101:  alu_res = bus.src_a | ~bus.src_b;
      default: alu_res = 32'd0;
    endcase
  end

  assign bus.alu_out = alu_res;
  assign bus.zero    = (alu_res == 32'd0);

  logic        sys_valid_q, sys_valid_d;
  logic [31:0] sys_data_q,  sys_data_d;
  logic        halted_q,    halted_d;

  // A held syscall re-fires every cycle; halting masks all later syscalls.
  always_comb begin
    sys_valid_d = 1'b0;
    sys_data_d  = sys_data_q;
    halted_d    = halted_q;
    if (is_sys && !halted_q) begin
      if (bus.syscall_info == SYS_PRINT_INT) begin
        sys_valid_d = 1'b1;
        sys_data_d  = bus.std_out;
      end
      if (bus.syscall_info == SYS_EXIT) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sys_valid_q <= 1'b0;
      sys_data_q  <= 32'd0;
      halted_q    <= 1'b0;
    end else begin
      sys_valid_q <= sys_valid_d;
      sys_data_q  <= sys_data_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.sys_out_valid = sys_valid_q;
  assign bus.sys_out_data  = sys_data_q;
  assign bus.halted        = halted_q;

endmodule

// File: tb/tb_mips_alu_ctrl_unit.sv
// Self-checking bench for mips_alu_ctrl_unit: directed corner cases plus
// randomized traffic compared against a behavioural reference model.
module tb_mips_alu_ctrl_unit;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;

  // Reference state for the clocked syscall outputs.
  logic        expValid;
  logic [31:0] expData;
  logic        expHalted;

  mips_alu_ctrl_unit_if bus ();

  mips_alu_ctrl_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Decode reference: {reg_dst, jump, branch, mem_read, mem_to_reg, alu_control[2:0], reg_write, alu_src, mem_write}.
  function automatic logic [10:0] refDecode(input logic [31:0] ins);
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    if (op == 0) begin
      if (fn == 32) return 11'b1_0_0_0_0_010_1_0_0;
      if (fn == 34) return 11'b1_0_0_0_0_110_1_0_0;
      if (fn == 36) return 11'b1_0_0_0_0_000_1_0_0;
      if (fn == 37) return 11'b1_0_0_0_0_001_1_0_0;
      if (fn == 42) return 11'b1_0_0_0_0_111_1_0_0;
      return 11'd0;
    end
    if (op == 35) return 11'b0_0_0_1_1_010_1_1_0;
    if (op == 43) return 11'b0_0_0_0_0_010_0_1_1;
    if (op == 4)  return 11'b0_0_1_0_0_110_0_0_0;
    if (op == 8)  return 11'b0_0_0_0_0_010_1_1_0;
    if (op == 2)  return 11'b0_1_0_0_0_000_0_0_0;
    return 11'd0;
  endfunction

  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b, input int ctl);
    longint unsigned la, lb, modulus;
    la = longint'(a);
    lb = longint'(b);
    modulus = 64'h1_0000_0000;
    if (ctl == 0) return a & b;
    if (ctl == 1) return a | b;
    if (ctl == 2) return 32'((la + lb) % modulus);
    if (ctl == 6) return 32'((la + modulus - lb) % modulus);
    if (ctl == 7) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    if (ctl == 4) return a & (32'hFFFF_FFFF ^ b);
    if (ctl == 5) return a | (32'hFFFF_FFFF ^ b);
    return 32'd0;
  endfunction

  function automatic logic [31:0] refPc(input logic [31:0] pcIn);
    longint unsigned sum;
    sum = longint'(pcIn) + 64'd4;
    if (sum >= 64'h1_0000_0000) sum = sum - 64'h1_0000_0000;
    return sum[31:0];
  endfunction

  function automatic logic [10:0] observedDecode();
    return {bus.reg_dst, bus.jump, bus.branch, bus.mem_read, bus.mem_to_reg,
            bus.alu_control, bus.reg_write, bus.alu_src, bus.mem_write};
  endfunction

  task automatic applyStimulus(input logic [31:0] pcIn, input logic [31:0] ins,
                               input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
    bus.pc      = pcIn;
    bus.instr   = ins;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.alu_ctl = ctl;
    #1;
  endtask

  task automatic checkComb(input string tag);
    checkOutput({tag, "_pc4"},    64'(bus.pc_plus4),   64'(refPc(bus.pc)));
    checkOutput({tag, "_decode"}, 64'(observedDecode()), 64'(refDecode(bus.instr)));
    checkOutput({tag, "_alu"},    64'(bus.alu_out),    64'(refAlu(bus.src_a, bus.src_b, int'(bus.alu_ctl))));
    checkOutput({tag, "_zero"},   64'(bus.zero),       64'(refAlu(bus.src_a, bus.src_b, int'(bus.alu_ctl)) == 32'd0));
  endtask

  // Called after a negedge with the syscall inputs already set: advance model, clock, check.
  task automatic stepSyscall(input string tag);
    bit isSys;
    isSys = (bus.instr[31:26] == 6'd0) && (bus.instr[5:0] == 6'd12);
    expValid = 1'b0;
    if (isSys && !expHalted && bus.syscall_info == 32'd1) begin
      expValid = 1'b1;
      expData  = bus.std_out;
    end
    if (isSys && !expHalted && bus.syscall_info == 32'd10) expHalted = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"},  64'(bus.sys_out_valid), 64'(expValid));
    checkOutput({tag, "_data"},   64'(bus.sys_out_data),  64'(expData));
    checkOutput({tag, "_halted"}, 64'(bus.halted),        64'(expHalted));
  endtask

  task automatic pulseResetCheck(input string tag);
    reset = 1'b1;
    #1;
    expValid = 1'b0; expData = 32'd0; expHalted = 1'b0;
    checkOutput({tag, "_valid"},  64'(bus.sys_out_valid), 64'(expValid));
    checkOutput({tag, "_data"},   64'(bus.sys_out_data),  64'(expData));
    checkOutput({tag, "_halted"}, 64'(bus.halted),        64'(expHalted));
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] edgeVals [6];
    logic [5:0]  ops      [8];
    logic [5:0]  functs   [7];
    logic [31:0] ins;
    testCount = 0;
    failCount = 0;
    edgeVals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h5};
    ops      = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h0D};
    functs   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h0C, 6'h21};

    reset = 1'b1;
    bus.syscall_info = 32'd0;
    bus.std_out      = 32'd0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    expValid = 1'b0; expData = 32'd0; expHalted = 1'b0;
    checkOutput("rst_valid",  64'(bus.sys_out_valid), 64'd0);
    checkOutput("rst_data",   64'(bus.sys_out_data),  64'd0);
    checkOutput("rst_halted", 64'(bus.halted),        64'd0);

    // Directed combinational corners.
    applyStimulus(32'h0040_0000, 32'h8C08_0004, 32'h7FFF_FFFF, 32'h1, 3'b010);
    checkOutput("add_ovf", 64'(bus.alu_out), 64'h8000_0000);
    checkOutput("pc_basic", 64'(bus.pc_plus4), 64'h0040_0004);
    checkOutput("dec_lw", 64'(observedDecode()), 64'(11'b0_0_0_1_1_010_1_1_0));
    applyStimulus(32'hFFFF_FFFC, 32'hAC08_0004, 32'h5, 32'h5, 3'b110);
    checkOutput("sub_zero_val", 64'(bus.alu_out), 64'h0);
    checkOutput("sub_zero_flag", 64'(bus.zero), 64'h1);
    checkOutput("pc_wrap", 64'(bus.pc_plus4), 64'h0);
    checkOutput("dec_sw", 64'(observedDecode()), 64'(11'b0_0_0_0_0_010_0_1_1));
    applyStimulus(32'h0, 32'h1109_FFFE, 32'hFFFF_FFFF, 32'h1, 3'b111);
    checkOutput("slt_neg", 64'(bus.alu_out), 64'h1);
    checkOutput("dec_beq", 64'(observedDecode()), 64'(11'b0_0_1_0_0_110_0_0_0));
    applyStimulus(32'h0, 32'hFC00_0000, 32'h1, 32'hFFFF_FFFF, 3'b111);
    checkOutput("slt_pos", 64'(bus.alu_out), 64'h0);
    checkOutput("dec_op3f", 64'(observedDecode()), 64'h0);
    for (int f = 0; f < 5; f++) begin
      applyStimulus(32'h0, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, functs[f]}, 32'h0, 32'h0, 3'b000);
      checkComb("dec_rtype");
    end

    // Randomized combinational traffic.
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) ins[5:0] = functs[$urandom_range(0, 6)];
      applyStimulus(($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom),
                    ins,
                    ($urandom_range(0, 2) == 0) ? edgeVals[$urandom_range(0, 5)] : 32'($urandom),
                    ($urandom_range(0, 2) == 0) ? edgeVals[$urandom_range(0, 5)] : 32'($urandom),
                    3'($urandom_range(0, 7)));
      checkComb("rand");
    end

    @(negedge clk);
    reset = 1'b0;

    // Directed print, then release.
    @(negedge clk);
    bus.instr = 32'h0000_000C; bus.syscall_info = 32'd1; bus.std_out = 32'd42;
    stepSyscall("print");
    checkOutput("print_data42", 64'(bus.sys_out_data), 64'd42);
    @(negedge clk);
    bus.instr = 32'h0;
    stepSyscall("print_end");
    checkOutput("print_end_valid0", 64'(bus.sys_out_valid), 64'd0);

    // Reset in the middle of a pulse.
    @(negedge clk);
    bus.instr = 32'h0000_000C; bus.std_out = 32'd7;
    stepSyscall("pulse");
    pulseResetCheck("midpulse_rst");

    // Exit, then a print that must be ignored, then async reset clears halt.
    @(negedge clk);
    bus.syscall_info = 32'd10;
    stepSyscall("exit");
    checkOutput("exit_halted", 64'(bus.halted), 64'd1);
    @(negedge clk);
    bus.syscall_info = 32'd1; bus.std_out = 32'd99;
    stepSyscall("post_halt");
    checkOutput("post_halt_nopulse", 64'(bus.sys_out_valid), 64'd0);
    #2;
    pulseResetCheck("halt_rst");

    // Randomized syscall traffic with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) bus.instr = {6'd0, 20'($urandom), 6'b001100};
      else                           bus.instr = $urandom;
      case ($urandom_range(0, 19))
        0:                bus.syscall_info = 32'd10;
        1, 2, 3:          bus.syscall_info = $urandom;
        default:          bus.syscall_info = 32'd1;
      endcase
      bus.std_out = $urandom;
      stepSyscall("rand_sys");
      if ($urandom_range(0, 29) == 0) begin
        #1;
        pulseResetCheck("rand_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
